shift_rows_pipe: RTL and testbench
==================================

Name: shift_rows_pipe

Overview:
- Registered, parametrised Rijndael ShiftRows / InvShiftRows unit; supports block widths NB=4, 6 or 8 columns (128/192/256-bit state).
- Per-transfer mode bit selects the forward (cipher) or inverse (decipher) permutation, so one instance serves both datapaths.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round pipeline, with valid/ready handshakes on both sides.
- Optional skid buffer gives full throughput with a registered in_ready.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; any other value is a elaboration error.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single output register, in_ready = !out_valid || out_ready.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input state valid
- in_ready  output  1  unit accepts input this cycle
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
- in_data  input  32*NB  input state
- out_valid  output  1  output state valid
- out_ready  input  1  downstream accepts output
- out_inv  output  1  mode bit that accompanied out_data
- out_data  output  32*NB  permuted state
- blk_cnt  output  CNT_W  number of output transfers completed, wraps modulo 2^CNT_W

Behaviour:
- Byte layout: s[r][c] = in_data[32*NB-1-8*(4c+r) -: 8], with r = 0..3 and c = 0..NB-1; byte 0 is at the MSB, column-major.
- Row offsets: NB=4 or 6 → 0,1,2,3; NB=8 → 0,1,3,4.
- Forward permutation: out[r][c] = in[r][(c+off_r) mod NB].
- Inverse permutation: out[r][c] = in[r][(c-off_r+NB) mod NB].
- The permutation is applied combinationally on the input side; the result is registered together with in_inv.
- Input transfer occurs when in_valid && in_ready at a rising edge; output transfer occurs when out_valid && out_ready.
- Latency: a transfer at edge k makes the word visible on out_data with out_valid=1 after edge k (the following cycle), provided the pipeline is empty.
- Throughput is one word per cycle while out_ready=1.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - The output register loads on every input transfer.
- SKID=1, states EMPTY / ONE / FULL (0, 1 or 2 words held):
  - in_ready is a register, equal to (state != FULL).
  - EMPTY + input transfer → ONE.
  - ONE + input transfer without output transfer → FULL; the word goes to the skid register.
  - ONE + output transfer without input transfer → EMPTY.
  - ONE + both transfers → stays ONE; the main register reloads.
  - FULL + output transfer → ONE; the skid word moves to the main register.
  - No input transfer is possible in FULL.
- Held-data rule: out_data and out_inv stay stable while out_valid=1 and out_ready=0.
- Ordering: words leave in arrival order; no word is dropped or duplicated.
- blk_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset (rst=1 at an edge, from any state, including mid-stall or FULL): out_valid=0, in_ready=1 (SKID=1), state=EMPTY, blk_cnt=0, out_data=0, out_inv=0. Held words are discarded.
- Inputs presented while rst=1 are ignored.
- in_inv may change on every transfer; no bubble is inserted when the mode switches.

Test Plan:
- NB=4, in_inv=0, in_data=000102030405060708090a0b0c0d0e0f, out_ready=1 → out_data=00050a0f04090e03080d02070c01060b one cycle later; blk_cnt=1.
- NB=4, in_inv=1, same in_data → out_data=000d0a0704010e0b0805020f0c090603, out_inv=1.
- Round trip: forward result fed back with in_inv=1 → original data is restored. Run 1000 random words per NB in {4,6,8}. For NB=8 forward with byte value = index, check out[3][0]=0x13 and out[2][0]=0x0e.
- SKID=1 backpressure: stream 10 words with out_ready toggling randomly → in_ready falls only when 2 words are held, order is preserved, data is stable while stalled, and blk_cnt=10 at the end.
- Assert rst while FULL with out_ready=0 → the next cycle shows out_valid=0, in_ready=1, blk_cnt=0; a subsequent word passes with 1-cycle latency.
- CNT_W=4: 17 back-to-back transfers → blk_cnt wraps 15→0 and reads 1 at the end.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Registered Rijndael ShiftRows / InvShiftRows stage for 4, 6 or 8 column states,
// with valid/ready on both sides and an optional two-entry skid buffer.
module shift_rows_pipe #(
   parameter int NB    = 4,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_inv,
   input  logic [32*NB-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_inv,
   output logic [32*NB-1:0]    out_data,
   output logic [CNT_W-1:0]    blk_cnt
);
   localparam int W = 32 * NB;

   if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   logic [W-1:0]     perm_data;
   logic [W-1:0]     main_data_reg;
   logic             main_inv_reg;
   logic [W-1:0]     skid_data_reg;
   logic             skid_inv_reg;
   logic [CNT_W-1:0] blk_cnt_reg;

   logic load_main;
   logic load_skid;
   logic main_from_skid;
   logic out_valid_int;
   logic in_ready_int;
   logic in_xfer;
   logic out_xfer;

   // Pure wiring: each output byte picks its source column from the row offset.
   for (genvar gi = 0; gi < 4 * NB; gi++) begin : g_byte
      localparam int R     = gi % 4;
      localparam int C     = gi / 4;
      localparam int OFF   = (NB == 8 && R >= 2) ? R + 1 : R;
      localparam int SRC_F = (C + OFF) % NB;
      localparam int SRC_I = (C - OFF + NB) % NB;
      assign perm_data[W-1-8*gi -: 8] = in_inv ? in_data[W-1-8*(4*SRC_I+R) -: 8]
                                               : in_data[W-1-8*(4*SRC_F+R) -: 8];
   end

   assign in_xfer  = in_valid && in_ready_int;
   assign out_xfer = out_valid_int && out_ready;

   if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
      state_t state_reg;
      state_t state_next;
      logic   in_ready_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
         end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
         end
      end

      always_comb begin
         state_next = state_reg;
         case (state_reg)
            EMPTY:   if (in_xfer) state_next = ONE;
            ONE: begin
               if (in_xfer && !out_xfer)      state_next = FULL;
               else if (!in_xfer && out_xfer) state_next = EMPTY;
            end
            FULL:    if (out_xfer) state_next = ONE;
            default: state_next = EMPTY;
         endcase
      end

      always_comb begin
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
         out_valid_int  = (state_reg != EMPTY);
         in_ready_int   = in_ready_reg;
         case (state_reg)
            EMPTY: load_main = in_xfer;
            ONE: begin
               load_main = in_xfer && out_xfer;
               load_skid = in_xfer && !out_xfer;
            end
            FULL:    main_from_skid = out_xfer;
            default: ;
         endcase
      end
   end else begin : g_noskid
      logic valid_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_reg <= 1'b0;
         end else if (in_xfer) begin
            valid_reg <= 1'b1;
         end else if (out_xfer) begin
            valid_reg <= 1'b0;
         end
      end

      always_comb begin
         out_valid_int  = valid_reg;
         in_ready_int   = !valid_reg || out_ready;
         load_main      = in_xfer;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_data_reg <= '0;
         main_inv_reg  <= 1'b0;
         skid_data_reg <= '0;
         skid_inv_reg  <= 1'b0;
         blk_cnt_reg   <= '0;
      end else begin
         if (load_main) begin
            main_data_reg <= perm_data;
            main_inv_reg  <= in_inv;
         end else if (main_from_skid) begin
            main_data_reg <= skid_data_reg;
            main_inv_reg  <= skid_inv_reg;
         end
         if (load_skid) begin
            skid_data_reg <= perm_data;
            skid_inv_reg  <= in_inv;
         end
         if (out_xfer) begin
            blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign in_ready  = in_ready_int;
   assign out_valid = out_valid_int;
   assign out_data  = main_data_reg;
   assign out_inv   = main_inv_reg;
   assign blk_cnt   = blk_cnt_reg;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Four shift_rows_pipe variants driven in lockstep; a per-instance scoreboard built on a
// byte-matrix reference permutation tracks every accepted word, handshake and counter.
module tb_shift_rows_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_inv = 1'b0;
   logic out_ready = 1'b0;
   logic [255:0] bus = '0;

   logic ov4, ov6, ov8, ovc, ir4, ir6, ir8, irc, oi4, oi6, oi8, oic;
   logic [127:0] od4, odc;
   logic [191:0] od6;
   logic [255:0] od8;
   logic [15:0]  bc4, bc6, bc8;
   logic [3:0]   bcc;

   logic         ov [4];
   logic         ir [4];
   logic         oi [4];
   logic [255:0] od [4];
   logic [15:0]  bc [4];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4), .SKID(1), .CNT_W(16)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_inv(in_inv),
      .in_data(bus[127:0]), .out_valid(ov4), .out_ready(out_ready), .out_inv(oi4),
      .out_data(od4), .blk_cnt(bc4));
   shift_rows_pipe #(.NB(6), .SKID(0), .CNT_W(16)) u_dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir6), .in_inv(in_inv),
      .in_data(bus[191:0]), .out_valid(ov6), .out_ready(out_ready), .out_inv(oi6),
      .out_data(od6), .blk_cnt(bc6));
   shift_rows_pipe #(.NB(8), .SKID(1), .CNT_W(16)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_inv(in_inv),
      .in_data(bus), .out_valid(ov8), .out_ready(out_ready), .out_inv(oi8),
      .out_data(od8), .blk_cnt(bc8));
   shift_rows_pipe #(.NB(4), .SKID(0), .CNT_W(4)) u_dutc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irc), .in_inv(in_inv),
      .in_data(bus[127:0]), .out_valid(ovc), .out_ready(out_ready), .out_inv(oic),
      .out_data(odc), .blk_cnt(bcc));

   assign ov[0] = ov4;  assign ov[1] = ov6;  assign ov[2] = ov8;  assign ov[3] = ovc;
   assign ir[0] = ir4;  assign ir[1] = ir6;  assign ir[2] = ir8;  assign ir[3] = irc;
   assign oi[0] = oi4;  assign oi[1] = oi6;  assign oi[2] = oi8;  assign oi[3] = oic;
   assign od[0] = {128'b0, od4};
   assign od[1] = {64'b0, od6};
   assign od[2] = od8;
   assign od[3] = {128'b0, odc};
   assign bc[0] = bc4;  assign bc[1] = bc6;  assign bc[2] = bc8;  assign bc[3] = {12'b0, bcc};

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nb_of(input int i);
      return (i == 1) ? 6 : (i == 2) ? 8 : 4;
   endfunction

   // Reference: unpack to a 4 x NB byte matrix, rotate each row, repack.
   function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input logic inv);
      logic [7:0]   s [4][8];
      logic [255:0] r;
      int off, src;
      r = '0;
      for (int c = 0; c < nb; c++)
         for (int row = 0; row < 4; row++)
            s[row][c] = d[32*nb-1-8*(4*c+row) -: 8];
      for (int row = 0; row < 4; row++) begin
         off = (nb == 8 && row >= 2) ? row + 1 : row;
         for (int c = 0; c < nb; c++) begin
            src = inv ? (c - off + nb) % nb : (c + off) % nb;
            r[32*nb-1-8*(4*c+row) -: 8] = s[row][src];
         end
      end
      return r;
   endfunction

   logic [255:0] exp_d [4][64];
   logic         exp_i [4][64];
   int wp [4] = '{0, 0, 0, 0};
   int rp [4] = '{0, 0, 0, 0};
   int cnt [4] = '{0, 0, 0, 0};
   int tot_out [4] = '{0, 0, 0, 0};
   logic armed = 1'b0;
   logic chk_rst = 1'b0;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         int occ;
         int cw;
         occ = wp[i] - rp[i];
         cw = (i == 3) ? 4 : 16;
         if (armed) begin
            if (!rst && chk_rst) begin
               check($sformatf("d%0d_rst_data", i), od[i], '0);
               check($sformatf("d%0d_rst_inv", i), 256'(oi[i]), '0);
               check($sformatf("d%0d_rst_ready", i), 256'(ir[i]), 256'(1));
            end
            check($sformatf("d%0d_valid", i), 256'(ov[i]), 256'(occ != 0));
            if (i == 0 || i == 2)
               check($sformatf("d%0d_ready", i), 256'(ir[i]), 256'(occ != 2));
            else
               check($sformatf("d%0d_ready", i), 256'(ir[i]), 256'(occ == 0 || out_ready));
            if (occ != 0) begin
               check($sformatf("d%0d_data", i), od[i], exp_d[i][rp[i] % 64]);
               check($sformatf("d%0d_inv", i), 256'(oi[i]), 256'(exp_i[i][rp[i] % 64]));
            end
            check($sformatf("d%0d_cnt", i), 256'(bc[i]), 256'(cnt[i] & ((1 << cw) - 1)));
         end
         if (rst) begin
            wp[i] = 0;
            rp[i] = 0;
            cnt[i] = 0;
         end else begin
            if (ov[i] && out_ready) begin
               rp[i]++;
               cnt[i]++;
               tot_out[i]++;
            end
            if (in_valid && ir[i]) begin
               exp_d[i][wp[i] % 64] = ref_perm(bus, nb_of(i), in_inv);
               exp_i[i][wp[i] % 64] = in_inv;
               wp[i]++;
            end
         end
      end
      if (rst) armed = 1'b1;
      chk_rst = rst;
   end

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send_one(input logic [255:0] d, input logic inv);
      bus = d;
      in_inv = inv;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [255:0] rand_bus();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      logic [255:0] w;
      int sent, cyc, base [4];
      logic acc, done;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      send_one({128'b0, 128'h000102030405060708090a0b0c0d0e0f}, 1'b0);
      check("fwd4_valid", 256'(ov[0]), 256'(1));
      check("fwd4_data", od[0], {128'b0, 128'h00050a0f04090e03080d02070c01060b});
      check("fwd4_inv", 256'(oi[0]), 256'(0));
      @(posedge clk); #1;
      check("fwd4_cnt", 256'(bc[0]), 256'(1));

      send_one({128'b0, 128'h000102030405060708090a0b0c0d0e0f}, 1'b1);
      check("inv4_data", od[0], {128'b0, 128'h000d0a0704010e0b0805020f0c090603});
      check("inv4_inv", 256'(oi[0]), 256'(1));

      send_one({128'b0, 128'h00050a0f04090e03080d02070c01060b}, 1'b1);
      check("rtrip4_data", od[0], {128'b0, 128'h000102030405060708090a0b0c0d0e0f});

      for (int k = 0; k < 32; k++) w[255-8*k -: 8] = 8'(k);
      send_one(w, 1'b0);
      check("nb8_r3c0", 256'(od[2][231:224]), 256'(8'h13));
      check("nb8_r2c0", 256'(od[2][239:232]), 256'(8'h0e));

      // Ten words with sticky valid and random backpressure on the output side.
      pulse_rst();
      sent = 0;
      cyc = 0;
      bus = rand_bus();
      in_inv = 1'($urandom);
      while (sent < 10 && cyc < 500) begin
         in_valid = 1'b1;
         out_ready = 1'($urandom);
         @(negedge clk);
         acc = ir[0];
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            sent++;
            bus = rand_bus();
            in_inv = 1'($urandom);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("bp_cnt", 256'(bc[0]), 256'(10));

      // Fill the skid instance, then reset it while stalled.
      pulse_rst();
      out_ready = 1'b0;
      in_valid = 1'b1;
      bus = rand_bus();
      @(posedge clk); #1;
      bus = rand_bus();
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("full_ready", 256'(ir[0]), 256'(0));
      check("full_valid", 256'(ov[0]), 256'(1));
      rst = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      check("rstfull_valid", 256'(ov[0]), 256'(0));
      check("rstfull_ready", 256'(ir[0]), 256'(1));
      check("rstfull_cnt", 256'(bc[0]), 256'(0));
      w = rand_bus();
      send_one(w, 1'b1);
      check("post_rst_valid", 256'(ov[0]), 256'(1));
      check("post_rst_data", od[0], ref_perm({128'b0, w[127:0]}, 4, 1'b1));

      // 17 back-to-back words: the 4-bit counter wraps to 1.
      pulse_rst();
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         bus = rand_bus();
         in_inv = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("wrap_cntc", 256'(bc[3]), 256'(1));
      check("wrap_cnt4", 256'(bc[0]), 256'(17));

      // Random traffic until every instance has delivered at least 1000 words.
      for (int i = 0; i < 4; i++) base[i] = tot_out[i];
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 20000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_inv = 1'($urandom);
         bus = rand_bus();
         @(posedge clk); #1;
         cyc++;
         done = 1'b1;
         for (int i = 0; i < 4; i++)
            if (tot_out[i] - base[i] < 1000) done = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rand_budget", 256'(done), 256'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
